// File: rtl/rot_pkg.sv
// Shared rotate helpers and the FSM state encoding for the rotate-amount search.
package rot_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int ROT_MAX_W = 64;

    // Width-generic rotate-left by one; callers zero-extend in and truncate out.
    function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v, input int w);
        logic [ROT_MAX_W-1:0] mask;
        mask = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction
endpackage

// File: rtl/rot_amount_ctrl.sv
// Search FSM: owns the candidate counter and the start/busy/done handshake.
module rot_amount_ctrl
    import rot_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          hit,
    output logic          busy,
    output logic          done,
    output logic          load,
    output logic          step,
    output logic          finish,
    output logic [AW-1:0] cnt
);
    state_t state, state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (load)      cnt <= '0;
            else if (step) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                load     = 1'b1;
                state_nx = ST_SEARCH;
            end
            ST_SEARCH: if (hit || cnt == AW'(W - 1)) begin
                finish   = 1'b1;
                state_nx = ST_DONE;
            end else begin
                step = 1'b1;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SEARCH);
    assign done = (state == ST_DONE);
endmodule

// File: rtl/rot_amount_finder.sv
// Finds the smallest left-rotate amount mapping d_ref onto d_rot, one candidate per clock.
module rot_amount_finder
    import rot_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  d_ref,
    input  logic [W-1:0]  d_rot,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] amt_left,
    output logic [AW-1:0] amt_right
);
    logic [W-1:0]  cand, target;
    logic [AW-1:0] cnt;
    logic          hit, load, step, finish;

    assign hit = (cand == target);

    rot_amount_ctrl #(.W(W), .AW(AW)) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .hit    (hit),
        .busy   (busy),
        .done   (done),
        .load   (load),
        .step   (step),
        .finish (finish),
        .cnt    (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= '0;
            target <= '0;
        end else if (load) begin
            cand   <= d_ref;
            target <= d_rot;
        end else if (step) begin
            cand <= W'(rotl1(ROT_MAX_W'(cand), W));
        end
    end

    // Result holds until the next search completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found    <= 1'b0;
            amt_left <= '0;
        end else if (finish) begin
            found    <= hit;
            amt_left <= hit ? cnt : '0;
        end
    end

    assign amt_right = '0 - amt_left;
endmodule

// File: tb/tb_rot_amount_finder.sv
// Randomized and directed checks of rot_amount_finder against a rotation-search model.
module tb_rot_amount_finder;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] d_ref = '0, d_rot = '0;
    logic       busy, done, found;
    logic [1:0] amt_left, amt_right;

    int total = 0;
    int bad   = 0;

    rot_amount_finder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .d_ref     (d_ref),
        .d_rot     (d_rot),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .amt_left  (amt_left),
        .amt_right (amt_right)
    );

    always #5 clk = ~clk;

    // Smallest k with rotl(a,k)==b, or -1.
    function automatic int ref_amt(input int a, input int b);
        for (int k = 0; k < W; k++)
            if ((((a * (1 << k)) + (a / (1 << (W - k)))) % 16) == b) return k;
        return -1;
    endfunction

    function automatic int ref_rotl(input int a, input int k);
        return ((a * (1 << k)) + (a / (1 << (W - k)))) % 16;
    endfunction

    // Issues one search; lat counts edges with the accepting edge as 1.
    task automatic do_search(input logic [3:0] a, input logic [3:0] b,
                             output int lat, output int busy_cnt,
                             output logic done_after, output logic to);
        d_ref = a; d_rot = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d_ref = ~a; d_rot = ~b;
        lat = 1; busy_cnt = 0; to = 1'b1; done_after = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin to = 1'b0; break; end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, found, amt_left, amt_right} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=000000", {busy, done, found, amt_left, amt_right});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string nm, input logic [3:0] a, input logic [3:0] b);
        int lat, bc, k, elat;
        logic da, to;
        logic [1:0] el, er;
        k = ref_amt(a, b);
        el = (k < 0) ? 2'd0 : 2'(k);
        er = (k < 0) ? 2'd0 : 2'((W - k) % W);
        elat = (k < 0) ? W + 1 : k + 2;
        do_search(a, b, lat, bc, da, to);
        total++;
        if (to) begin
            bad++; $display("FAIL %s timeout a=%b b=%b", nm, a, b);
        end else if (found !== (k >= 0) || amt_left !== el || amt_right !== er) begin
            bad++;
            $display("FAIL %s a=%b b=%b got f=%b l=%0d r=%0d exp f=%b l=%0d r=%0d",
                     nm, a, b, found, amt_left, amt_right, k >= 0, el, er);
        end
        total++;
        if (lat !== elat || bc !== elat - 1 || da !== 1'b0) begin
            bad++;
            $display("FAIL %s_timing a=%b b=%b got lat=%0d busy=%0d done_after=%b exp lat=%0d busy=%0d done_after=0",
                     nm, a, b, lat, bc, da, elat, elat - 1);
        end
    endtask

    task automatic test_directed();
        check_op("basic",    4'b1001, 4'b0011);
        check_op("identity", 4'b1010, 4'b1010);
        check_op("periodic", 4'b0101, 4'b1010);
        check_op("nomatch",  4'b0001, 4'b0011);
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 16; a++)
            for (int r = 0; r < W; r++)
                check_op("sweep", 4'(a), 4'(ref_rotl(a, r)));
        for (int i = 0; i < 10; i++)
            check_op("random", 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        d_ref = 4'b1000; d_rot = 4'b0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; d_ref = 4'b0001; d_rot = 4'b0100;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        total++;
        if (pulses !== 1 || found !== 1'b1 || amt_left !== 2'd1 || amt_right !== 2'd3) begin
            bad++;
            $display("FAIL ignored_start got pulses=%0d f=%b l=%0d r=%0d exp pulses=1 f=1 l=1 r=3",
                     pulses, found, amt_left, amt_right);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        d_ref = 4'b0001; d_rot = 4'b0011; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, found, amt_left} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=00000", {busy, done, found, amt_left});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) pulses++;
            @(posedge clk); #1;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL reset_mid_quiet got activity=%0d exp=0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        d_ref = 4'b0101; d_rot = 4'b1010; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        total++;
        if (first < 0 || second - first !== 4 || amt_left !== 2'd1) begin
            bad++;
            $display("FAIL back_to_back got spacing=%0d l=%0d exp spacing=4 l=1", second - first, amt_left);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
